// File: rtl/operand_entry_fsm.sv
// Operand/opcode entry controller for the calculator ALU stage.
// Turns button rises into two hex operands and an opcode, and strobes calc on equal.
module operand_entry_fsm #(
  parameter int unsigned NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [21:0]           pb,
  output logic [4*NDIG-1:0]     valA,
  output logic [4*NDIG-1:0]     valB,
  output logic [3:0]            op,
  output logic                  calc,
  output logic [1:0]            state,
  output logic [4*NDIG-1:0]     disp_val
);

  localparam int unsigned W    = 4 * NDIG;
  localparam int unsigned CntW = $clog2(NDIG + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(NDIG);

  typedef enum logic [1:0] {
    StEntryA = 2'd0,
    StEntryB = 2'd1,
    StDone   = 2'd2
  } state_e;

  state_e          r_state, w_state_d;
  logic [W-1:0]    r_val_a, w_val_a_d;
  logic [W-1:0]    r_val_b, w_val_b_d;
  logic [3:0]      r_op, w_op_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_calc, w_calc_d;
  logic [21:0]     r_pb_prev;

  logic [21:0] w_rise;
  logic        w_clr, w_eq, w_op_any, w_dig_any;
  logic [3:0]  w_digit;
  logic [3:0]  w_op_code;

  assign w_rise    = pb & ~r_pb_prev;
  assign w_clr     = w_rise[21];
  assign w_eq      = w_rise[16];
  assign w_op_any  = |w_rise[20:17];
  assign w_dig_any = |w_rise[15:0];

  // Descending scans so the lowest set index is the last (winning) assignment.
  always_comb begin
    w_digit = '0;
    for (int i = 15; i >= 0; i--) begin
      if (w_rise[i]) w_digit = 4'(i);
    end
    w_op_code = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rise[17+i]) w_op_code = 4'(i + 1);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_val_a_d = r_val_a;
    w_val_b_d = r_val_b;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_calc_d  = 1'b0;

    if (w_clr) begin
      w_state_d = StEntryA;
      w_val_a_d = '0;
      w_val_b_d = '0;
      w_op_d    = '0;
      w_cnt_d   = '0;
    end else if (w_eq) begin
      case (r_state)
        StEntryB: begin
          if (r_cnt != '0) begin
            w_calc_d  = 1'b1;
            w_state_d = StDone;
          end
        end
        StDone:  w_calc_d = 1'b1;
        default: ;
      endcase
    end else if (w_op_any) begin
      w_op_d = w_op_code;
      // A fresh B operand starts unless we are only correcting the opcode.
      if (r_state != StEntryB) begin
        w_val_b_d = '0;
        w_cnt_d   = '0;
        w_state_d = StEntryB;
      end
    end else if (w_dig_any) begin
      case (r_state)
        StEntryA: begin
          if (r_cnt < CntMax) begin
            w_val_a_d = (r_val_a << 4) | W'(w_digit);
            w_cnt_d   = r_cnt + 1'b1;
          end
        end
        StEntryB: begin
          if (r_cnt < CntMax) begin
            w_val_b_d = (r_val_b << 4) | W'(w_digit);
            w_cnt_d   = r_cnt + 1'b1;
          end
        end
        StDone: begin
          w_val_a_d = W'(w_digit);
          w_val_b_d = '0;
          w_op_d    = '0;
          w_cnt_d   = CntW'(1);
          w_state_d = StEntryA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StEntryA;
      r_val_a   <= '0;
      r_val_b   <= '0;
      r_op      <= '0;
      r_cnt     <= '0;
      r_calc    <= 1'b0;
      r_pb_prev <= '0;
    end else begin
      r_state   <= w_state_d;
      r_val_a   <= w_val_a_d;
      r_val_b   <= w_val_b_d;
      r_op      <= w_op_d;
      r_cnt     <= w_cnt_d;
      r_calc    <= w_calc_d;
      r_pb_prev <= pb;
    end
  end

  assign valA     = r_val_a;
  assign valB     = r_val_b;
  assign op       = r_op;
  assign calc     = r_calc;
  assign state    = r_state;
  assign disp_val = (r_state == StEntryB) ? r_val_b : r_val_a;

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Scoreboard bench for operand_entry_fsm: a digit-list reference model predicts each cycle's
// outputs and every calc strobe; a negedge monitor pops and compares.
module tb_operand_entry_fsm;

  localparam int unsigned NDIG = 4;
  localparam int unsigned W    = 4 * NDIG;
  localparam logic [21:0] EQ   = 22'(1) << 16;
  localparam logic [21:0] ADD  = 22'(1) << 17;
  localparam logic [21:0] SUB  = 22'(1) << 18;
  localparam logic [21:0] DIV  = 22'(1) << 19;
  localparam logic [21:0] MUL  = 22'(1) << 20;
  localparam logic [21:0] CLR  = 22'(1) << 21;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [21:0]   pb;
  logic [W-1:0]  valA, valB, disp_val;
  logic [3:0]    op;
  logic          calc;
  logic [1:0]    state;

  operand_entry_fsm #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pb       (pb),
    .valA     (valA),
    .valB     (valB),
    .op       (op),
    .calc     (calc),
    .state    (state),
    .disp_val (disp_val)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, disp;
    logic [3:0]   op;
    logic         calc;
    logic [1:0]   st;
  } snap_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic [3:0]   op;
  } calc_t;

  typedef logic [3:0] nib_q_t[$];

  snap_t snap_q[$];
  calc_t calc_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: each operand is the list of digits keyed so far.
  nib_q_t      m_a, m_b;
  int          m_phase;  // 0 entering A, 1 entering B, 2 result shown
  logic [3:0]  m_op;
  logic        m_calc;
  logic [21:0] m_prev;

  function automatic logic [W-1:0] fold(input nib_q_t q);
    logic [W-1:0] v = '0;
    foreach (q[i]) v = v * 16 + W'(q[i]);
    return v;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.a    = fold(m_a);
    s.b    = fold(m_b);
    s.op   = m_op;
    s.calc = m_calc;
    s.st   = 2'(m_phase);
    s.disp = (m_phase == 1) ? s.b : s.a;
    return s;
  endfunction

  task automatic model_reset();
    m_a.delete();
    m_b.delete();
    m_phase = 0;
    m_op    = '0;
    m_calc  = 1'b0;
    m_prev  = '0;
  endtask

  task automatic model_step(input logic [21:0] p);
    logic [21:0] rise;
    int d, o;
    calc_t c;
    rise   = p & ~m_prev;
    m_prev = p;
    m_calc = 1'b0;
    d = -1;
    o = 0;
    for (int i = 0; i < 16; i++) if (rise[i] && d < 0) d = i;
    for (int i = 1; i <= 4; i++) if (rise[16+i] && o == 0) o = i;
    if (rise[21]) begin
      m_a.delete();
      m_b.delete();
      m_op    = '0;
      m_phase = 0;
    end else if (rise[16]) begin
      if (m_phase == 2 || (m_phase == 1 && m_b.size() > 0)) begin
        m_calc  = 1'b1;
        m_phase = 2;
        c.a  = fold(m_a);
        c.b  = fold(m_b);
        c.op = m_op;
        calc_q.push_back(c);
      end
    end else if (o > 0) begin
      if (m_phase != 1) m_b.delete();
      m_op    = 4'(o);
      m_phase = 1;
    end else if (d >= 0) begin
      if (m_phase == 2) begin
        m_a.delete();
        m_a.push_back(4'(d));
        m_b.delete();
        m_op    = '0;
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (m_a.size() < NDIG) m_a.push_back(4'(d));
      end else begin
        if (m_b.size() < NDIG) m_b.push_back(4'(d));
      end
    end
  endtask

  // Pushes what the DUT should show now, then drives the value sampled at the next edge.
  task automatic cycle(input logic [21:0] m);
    @(posedge clk);
    #1;
    snap_q.push_back(model_snap());
    pb = m;
    model_step(m);
  endtask

  task automatic press(input logic [21:0] m);
    cycle(m);
    cycle('0);
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [3:0] o, input logic c, input logic [1:0] st);
    check({tag, ".valA"}, 32'(valA), 32'(a));
    check({tag, ".valB"}, 32'(valB), 32'(b));
    check({tag, ".op"}, 32'(op), 32'(o));
    check({tag, ".calc"}, 32'(calc), 32'(c));
    check({tag, ".state"}, 32'(state), 32'(st));
  endtask

  function automatic logic [21:0] dig(input int d);
    return 22'(1) << d;
  endfunction

  always @(negedge clk) begin
    snap_t s;
    calc_t c;
    if (rst_n) begin
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        check("cyc.valA", 32'(valA), 32'(s.a));
        check("cyc.valB", 32'(valB), 32'(s.b));
        check("cyc.op", 32'(op), 32'(s.op));
        check("cyc.calc", 32'(calc), 32'(s.calc));
        check("cyc.state", 32'(state), 32'(s.st));
        check("cyc.disp", 32'(disp_val), 32'(s.disp));
      end
      if (calc === 1'b1) begin
        check("calc.pending", 32'(calc_q.size() > 0), 32'(1));
        if (calc_q.size() > 0) begin
          c = calc_q.pop_front();
          check("calc.valA", 32'(valA), 32'(c.a));
          check("calc.valB", 32'(valB), 32'(c.b));
          check("calc.op", 32'(op), 32'(c.op));
        end
      end
    end
  end

  initial begin
    logic [21:0] cur;
    int r, k;
    pb    = '0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    expect_out("reset", '0, '0, '0, 1'b0, 2'd0);
    check("reset.disp", 32'(disp_val), 32'(0));
    #20 rst_n = 1'b1;
    model_step(pb);

    // Basic entry and a single calc pulse.
    press(dig(1)); press(dig(2)); press(dig(10)); press(dig(11));
    press(ADD); press(dig(3)); press(EQ);
    expect_out("seq1", 16'h12AB, 16'h0003, 4'h1, 1'b1, 2'd2);
    cycle('0);
    check("seq1.calc_drop", 32'(calc), 32'(0));

    // Digit limit, then a held key gives one event.
    press(CLR);
    for (int i = 1; i <= 5; i++) press(dig(i));
    check("limit.valA", 32'(valA), 32'h1234);
    press(ADD);
    repeat (10) cycle(dig(7));
    cycle('0);
    check("hold.valB", 32'(valB), 32'h0007);

    // Ignored equals and opcode overwrite.
    press(CLR); press(EQ);
    expect_out("eqA", '0, '0, '0, 1'b0, 2'd0);
    press(SUB); press(EQ);
    expect_out("eqB0", '0, '0, 4'h2, 1'b0, 2'd1);
    press(MUL);
    expect_out("opover", '0, '0, 4'h4, 1'b0, 2'd1);

    // Arbitration.
    press(CLR); press(dig(1)); press(ADD); press(dig(5));
    press(CLR | EQ);
    expect_out("clr_eq", '0, '0, '0, 1'b0, 2'd0);
    press(dig(3) | dig(9));
    check("dig_prio.valA", 32'(valA), 32'h0003);

    // Operations starting from the result state.
    press(CLR); press(dig(9)); press(ADD); press(dig(1)); press(EQ);
    press(DIV);
    expect_out("chain", 16'h0009, '0, 4'h3, 1'b0, 2'd1);
    press(dig(1)); press(EQ); cycle('0); press(EQ);
    expect_out("recalc", 16'h0009, 16'h0001, 4'h3, 1'b1, 2'd2);
    press(dig(4));
    expect_out("newA", 16'h0004, '0, '0, 1'b0, 2'd0);

    // Asynchronous reset mid-entry, with equal held across release.
    press(CLR); press(dig(0)); press(dig(10)); press(dig(11)); press(dig(12));
    check("pre_rst.valA", 32'(valA), 32'h0ABC);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    expect_out("async_rst", '0, '0, '0, 1'b0, 2'd0);
    model_reset();
    pb = EQ;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    model_step(pb);
    repeat (4) cycle(EQ);
    cycle('0);
    expect_out("post_rst", '0, '0, '0, 1'b0, 2'd0);

    // Randomized traffic.
    cur = '0;
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
      end else if (r < 65) begin
        cur = '0;
      end else if (r < 95) begin
        k = $urandom_range(0, 99);
        if (k < 55)      cur = dig($urandom_range(0, 15));
        else if (k < 75) cur = EQ;
        else if (k < 95) cur = dig($urandom_range(17, 20));
        else             cur = CLR;
      end else begin
        cur = 22'($urandom);
      end
      cycle(cur);
    end
    repeat (4) cycle('0);
    @(negedge clk);
    #1;
    check("snap_q.drained", 32'(snap_q.size()), 32'(0));
    check("calc_q.drained", 32'(calc_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
